// File: rtl/tetris_pkg.sv
// Shared playfield constants, line-clear FSM states and score table.
package tetris_pkg;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int ID_W = 3;
   localparam int Y_W  = 5;
   localparam int X_W  = 5;

   localparam logic [ID_W-1:0] EMPTY_ID = '0;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      COPY,
      FILL,
      DONE
   } lc_state_t;

   localparam logic [15:0] SCORE_1 = 16'd40;
   localparam logic [15:0] SCORE_2 = 16'd100;
   localparam logic [15:0] SCORE_3 = 16'd300;
   localparam logic [15:0] SCORE_4 = 16'd1200;

   // Points awarded for a pass that removed n lines; anything above 4 pays as 4.
   function automatic logic [15:0] score_for_lines(input logic [Y_W-1:0] n);
      logic [15:0] pts;
      case (n)
         Y_W'(0): pts = '0;
         Y_W'(1): pts = SCORE_1;
         Y_W'(2): pts = SCORE_2;
         Y_W'(3): pts = SCORE_3;
         default: pts = SCORE_4;
      endcase
      return pts;
   endfunction

endpackage

// File: rtl/line_clear_score.sv
// Saturating score accumulator step: next_score = score + table[lines].
module line_clear_score
   import tetris_pkg::*;
(
   input  logic [Y_W-1:0] lines,
   input  logic [15:0]    score,
   output logic [15:0]    next_score
);

   logic [16:0] sum;

   // Add the pass reward with one guard bit and clamp at all-ones.
   always_comb begin
      sum        = {1'b0, score} + {1'b0, score_for_lines(lines)};
      next_score = sum[16] ? '1 : sum[15:0];
   end

endmodule

// File: rtl/line_clear.sv
// Line clear pass: scans the board bottom-up, drops full rows, compacts the
// rows above downward and zero-fills the vacated top rows.
// Optional scoring is enabled by defining LINE_CLEAR_SCORE_EN.
module line_clear
   import tetris_pkg::*;
(
   input  logic            clk,
   input  logic            Reset_n,
   input  logic            Start,
   output logic [Y_W-1:0]  rd_y,
   output logic [X_W-1:0]  rd_x,
   input  logic [ID_W-1:0] rd_id,
   output logic            wr_en,
   output logic [Y_W-1:0]  wr_y,
   output logic [X_W-1:0]  wr_x,
   output logic [ID_W-1:0] wr_id,
   output logic            Ready,
   output logic            Done,
   output logic [Y_W-1:0]  lines,
   output logic [15:0]     score
);

   localparam logic [Y_W-1:0] LAST_ROW = Y_W'(ROWS - 1);
   localparam logic [Y_W-1:0] ROWS_Y   = Y_W'(ROWS);
   localparam logic [X_W-1:0] LAST_COL = X_W'(COLS - 1);

   lc_state_t      state, state_n;
   logic [Y_W-1:0] src, src_n;
   logic [Y_W-1:0] dst, dst_n;
   logic [X_W-1:0] x, x_n;
   logic [Y_W-1:0] cnt, cnt_n;
   logic [Y_W-1:0] lines_q;

   // State and pass registers; reset aborts any pass in progress.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         src   <= '0;
         dst   <= '0;
         x     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         src   <= src_n;
         dst   <= dst_n;
         x     <= x_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state logic. Whenever src is about to step past the last row the
   // FSM goes straight to FILL, so SCAN never reads row ROWS.
   always_comb begin
      state_n = state;
      src_n   = src;
      dst_n   = dst;
      x_n     = x;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (Start) begin
               src_n   = '0;
               dst_n   = '0;
               x_n     = '0;
               cnt_n   = '0;
               state_n = SCAN;
            end
         end
         SCAN: begin
            if (rd_id == EMPTY_ID) begin
               x_n = '0;
               if (src == dst) begin
                  src_n = src + 1'b1;
                  dst_n = dst + 1'b1;
                  if (src == LAST_ROW) state_n = FILL;
               end else begin
                  state_n = COPY;
               end
            end else if (x != LAST_COL) begin
               x_n = x + 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
               src_n = src + 1'b1;
               x_n   = '0;
               if (src == LAST_ROW) state_n = FILL;
            end
         end
         COPY: begin
            if (x == LAST_COL) begin
               src_n   = src + 1'b1;
               dst_n   = dst + 1'b1;
               x_n     = '0;
               state_n = (src == LAST_ROW) ? FILL : SCAN;
            end else begin
               x_n = x + 1'b1;
            end
         end
         FILL: begin
            if (dst == ROWS_Y) begin
               state_n = DONE;
            end else if (x == LAST_COL) begin
               x_n   = '0;
               dst_n = dst + 1'b1;
            end else begin
               x_n = x + 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Board port drive and handshake outputs, decoded from the state register.
   always_comb begin
      rd_y  = src;
      rd_x  = x;
      wr_y  = dst;
      wr_x  = x;
      wr_en = (state == COPY) || ((state == FILL) && (dst != ROWS_Y));
      wr_id = (state == COPY) ? rd_id : EMPTY_ID;
      Ready = (state == IDLE);
      Done  = (state == DONE);
   end

   // Latch the line count of the finished pass.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n)            lines_q <= '0;
      else if (state == DONE)  lines_q <= cnt;
   end

   assign lines = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
   logic [15:0] score_q;
   logic [15:0] score_nx;

   line_clear_score u_score (
      .lines      (cnt),
      .score      (score_q),
      .next_score (score_nx)
   );

   // Accumulate the reward once per completed pass.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n)            score_q <= '0;
      else if (state == DONE)  score_q <= score_nx;
   end

   assign score = score_q;
`else
   assign score = '0;
`endif

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: behavioural board RAM plus a
// row-filtering reference model of a clear pass.
module tb_line_clear;
   import tetris_pkg::*;

   logic            clk = 1'b0;
   logic            Reset_n;
   logic            Start;
   logic [Y_W-1:0]  rd_y;
   logic [X_W-1:0]  rd_x;
   logic [ID_W-1:0] rd_id;
   logic            wr_en;
   logic [Y_W-1:0]  wr_y;
   logic [X_W-1:0]  wr_x;
   logic [ID_W-1:0] wr_id;
   logic            Ready;
   logic            Done;
   logic [Y_W-1:0]  lines;
   logic [15:0]     score;

   line_clear dut (
      .clk     (clk),
      .Reset_n (Reset_n),
      .Start   (Start),
      .rd_y    (rd_y),
      .rd_x    (rd_x),
      .rd_id   (rd_id),
      .wr_en   (wr_en),
      .wr_y    (wr_y),
      .wr_x    (wr_x),
      .wr_id   (wr_id),
      .Ready   (Ready),
      .Done    (Done),
      .lines   (lines),
      .score   (score)
   );

   always #5 clk = ~clk;

   logic [ID_W-1:0] board    [ROWS][COLS];
   logic [ID_W-1:0] img      [ROWS][COLS];
   logic [ID_W-1:0] snap     [ROWS][COLS];
   logic [ID_W-1:0] exp_board[ROWS][COLS];
   logic            load_req = 1'b0;
   int              wlog_y[$];
   int              wlog_rdy[$];

   int checks = 0;
   int errors = 0;
   int exp_lines, exp_writes, exp_score;

   // Combinational read port; out-of-range reads return empty.
   always_comb begin
      if (int'(rd_y) < ROWS && int'(rd_x) < COLS) rd_id = board[int'(rd_y)][int'(rd_x)];
      else                                        rd_id = '0;
   end

   // Synchronous write port, plus bench-side image loading and a write log.
   always @(posedge clk) begin
      if (load_req) begin
         board <= img;
      end else if (wr_en) begin
         if (int'(wr_y) < ROWS && int'(wr_x) < COLS) board[int'(wr_y)][int'(wr_x)] <= wr_id;
         wlog_y.push_back(int'(wr_y));
         wlog_rdy.push_back(int'(rd_y));
      end
   end

   task automatic check(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int pts(input int n);
      if (n == 0) return 0;
      if (n == 1) return 40;
      if (n == 2) return 100;
      if (n == 3) return 300;
      return 1200;
   endfunction

   task automatic load_img();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic clear_img();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) img[r][c] = '0;
   endtask

   // Reference: keep non-full rows in order, pad with empty rows on top.
   // Rows below the lowest full row are untouched; every row from there up is written.
   task automatic model_pass();
      int k, first_full;
      bit full;
      snap = board;
      exp_lines  = 0;
      k          = 0;
      first_full = ROWS;
      for (int r = 0; r < ROWS; r++) begin
         full = 1'b1;
         for (int c = 0; c < COLS; c++) if (snap[r][c] == 0) full = 1'b0;
         if (full) begin
            exp_lines++;
            if (first_full == ROWS) first_full = r;
         end else begin
            for (int c = 0; c < COLS; c++) exp_board[k][c] = snap[r][c];
            k++;
         end
      end
      for (int r = k; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) exp_board[r][c] = '0;
      exp_writes = COLS * (ROWS - first_full);
`ifdef LINE_CLEAR_SCORE_EN
      exp_score = exp_score + pts(exp_lines);
      if (exp_score > 65535) exp_score = 65535;
`endif
   endtask

   task automatic check_result(input string tag, input int base);
      int mism;
      mism = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) if (board[r][c] !== exp_board[r][c]) mism++;
      check({tag, "_lines"}, lines, exp_lines);
      check({tag, "_writes"}, wlog_y.size() - base, exp_writes);
      check({tag, "_board"}, mism, 0);
      check({tag, "_score"}, score, exp_score);
      check({tag, "_ready"}, Ready, 1);
   endtask

   // Wait (bounded) for Done; returns cycles waited, -1 on timeout.
   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (Done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic run_pass(input string tag);
      int base, cyc;
      model_pass();
      base = wlog_y.size();
      @(negedge clk);
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      check({tag, "_busy"}, Ready, 0);
      wait_done(cyc);
      check({tag, "_done_seen"}, (cyc >= 0), 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, Done, 0);
      check_result(tag, base);
   endtask

   initial begin
      int base, cyc, busy_bad;
      Reset_n   = 1'b0;
      Start     = 1'b0;
      exp_score = 0;
      clear_img();
      load_img();
      @(negedge clk);
      check("rst_ready", Ready, 1);
      check("rst_done", Done, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_coords", {rd_y, rd_x, wr_y, wr_x}, 0);
      check("rst_wr_id", wr_id, 0);
      check("rst_lines", lines, 0);
      check("rst_score", score, 0);
      Reset_n = 1'b1;

      // 1: empty board
      run_pass("empty");

      // 2: row 0 full, single block above
      clear_img();
      for (int c = 0; c < COLS; c++) img[0][c] = 3'd1;
      img[1][3] = 3'd2;
      load_img();
      base = wlog_y.size();
      run_pass("one_line");
      check("one_line_first_wr_y", wlog_y[base], 0);
      check("one_line_first_rd_y", wlog_rdy[base], 1);

      // 3: four full rows
      clear_img();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < COLS; c++) img[r][c] = 3'(r + 1);
      img[4][0] = 3'd5;
      load_img();
      run_pass("tetris");

      // 4: only top row full
      clear_img();
      for (int c = 0; c < COLS; c++) img[ROWS-1][c] = 3'd6;
      load_img();
      base = wlog_y.size();
      run_pass("top_row");
      check("top_row_first_wr_y", wlog_y[base], ROWS - 1);

      // 5: reset during COPY
      clear_img();
      for (int c = 0; c < COLS; c++) img[0][c] = 3'd1;
      img[1][3] = 3'd2;
      load_img();
      @(negedge clk);
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      cyc = -1;
      for (int i = 0; i < 200; i++) begin
         if (wr_en) begin
            cyc = i;
            break;
         end
         @(negedge clk);
      end
      check("abort_copy_seen", (cyc >= 0), 1);
      Reset_n = 1'b0;
      #1;
      exp_score = 0;
      check("abort_wr_en", wr_en, 0);
      check("abort_ready", Ready, 1);
      check("abort_done", Done, 0);
      check("abort_lines", lines, 0);
      check("abort_score", score, 0);
      @(negedge clk);
      Reset_n = 1'b1;
      run_pass("after_abort");

      // 6: Start held high through a pass
      clear_img();
      for (int c = 0; c < COLS; c++) img[0][c] = 3'd1;
      img[1][3] = 3'd2;
      load_img();
      model_pass();
      base = wlog_y.size();
      @(negedge clk);
      Start    = 1'b1;
      busy_bad = 0;
      cyc      = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (Done) begin
            cyc = i;
            break;
         end
         if (Ready) busy_bad++;
      end
      check("held_done_seen", (cyc >= 0), 1);
      check("held_no_restart", busy_bad, 0);
      @(negedge clk);
      check_result("held_pass1", base);
      model_pass();
      base = wlog_y.size();
      @(negedge clk);
      check("held_restart", Ready, 0);
      Start = 1'b0;
      wait_done(cyc);
      check("held2_done_seen", (cyc >= 0), 1);
      @(negedge clk);
      check_result("held_pass2", base);

      // Randomized boards
      for (int t = 0; t < 10; t++) begin
         int top;
         clear_img();
         top = $urandom_range(ROWS, 1);
         for (int r = 0; r < top; r++) begin
            if ($urandom % 3 == 0) begin
               for (int c = 0; c < COLS; c++) img[r][c] = 3'($urandom_range(7, 1));
            end else begin
               for (int c = 0; c < COLS; c++) img[r][c] = 3'($urandom_range(7, 0));
               img[r][$urandom_range(COLS - 1, 0)] = '0;
            end
         end
         load_img();
         run_pass($sformatf("rand%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
